// File: rtl/vc_switch_allocator_pkg.sv
// Shared types and helpers for the output-port switch allocator.
package vc_switch_allocator_pkg;

  localparam int CFG_W  = 16;
  localparam int STAT_W = 16;

  // Number of bits needed to hold the value 'depth'.
  function automatic int CLogB2(input int depth);
    int r;
    int d;
    r = 0;
    d = depth;
    for (int k = 0; k < 32; k++) begin
      if (d > 0) begin
        r = r + 1;
        d = d >> 1;
      end
    end
    return r;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/vc_switch_allocator_if.sv
// Request/grant/credit bundle between the input queues, the downstream
// credit return and the switch allocator.
interface vc_switch_allocator_if #(
  parameter int NINPUTS  = 10,
  parameter int LOG_NVCS = 1
);
  logic [NINPUTS-1:0]          req;
  logic [NINPUTS*LOG_NVCS-1:0] req_vc;
  logic [NINPUTS-1:0]          req_tail;
  logic [NINPUTS-1:0]          grant;
  logic                        grant_valid;
  logic [LOG_NVCS-1:0]         grant_vc;
  logic                        credit_in_valid;
  logic [LOG_NVCS-1:0]         credit_in_vc;

  modport master (
    output req, req_vc, req_tail, credit_in_valid, credit_in_vc,
    input  grant, grant_valid, grant_vc
  );

  modport slave (
    input  req, req_vc, req_tail, credit_in_valid, credit_in_vc,
    output grant, grant_valid, grant_vc
  );
endinterface

// File: rtl/vc_switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning upward
// from 'base', wrapping at N, returned as a one-hot vector.
module rr_arbiter #(
  parameter int N  = 10,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] base,
  output logic [N-1:0]  grant
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Rotating priority scan; the extra sum bit keeps base+k from wrapping early.
  always_comb begin
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, base} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (req[idx] && (grant == '0)) grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vc_switch_allocator.sv
// Credit-aware switch allocator for one router output port.
// Holds the port from head to tail flit, tracks downstream credits per
// output VC, and issues a same-cycle one-hot grant that pops the winner.
// Optional: define SW_ALLOC_STATS_EN to build the stall-cycle counter.
module vc_switch_allocator
  import vc_switch_allocator_pkg::*;
#(
  parameter int NPORTS     = 5,
  parameter int NVCS       = 2,
  parameter int CREDIT_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CFG_W-1:0]  config_in,
  input  logic              config_in_valid,
  output logic [CFG_W-1:0]  config_out,
  output logic              config_out_valid,
  vc_switch_allocator_if.slave bus,
  output logic              is_quiescent,
  output logic              error,
  output logic [STAT_W-1:0] stall_count
);

  localparam int NINPUTS = NPORTS * NVCS;
  localparam int LW      = (NVCS > 1) ? CLogB2(NVCS - 1) : 1;
  localparam int PW      = CLogB2(NINPUTS - 1);
  localparam int CW      = CLogB2(CREDIT_MAX) + 1;

  typedef logic [CW-1:0] cnt_t;

  alloc_state_t               state;
  logic [PW-1:0]              rr_ptr, lock_idx, gidx, next_ptr;
  logic [LW-1:0]              lock_vc;
  cnt_t                       limit, cfg_limit;
  cnt_t [NVCS-1:0]            credit;
  logic [NINPUTS-1:0][LW-1:0] vcs;
  logic [NINPUTS-1:0]         elig, arb_grant, grant_c;
  logic [NVCS-1:0]            inc, dec, ovf;
  logic                       grant_any, grant_tail, vc_err;

  assign vcs = bus.req_vc;

  // A requester is eligible only if its target VC has a credit left.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NINPUTS; i++)
      elig[i] = bus.req[i] && (credit[vcs[i]] != '0);
  end

  rr_arbiter #(.N(NINPUTS), .PW(PW)) u_arb (
    .req   (elig),
    .base  (rr_ptr),
    .grant (arb_grant)
  );

  // Grant select: open arbitration when idle, only the lock holder when locked.
  always_comb begin
    grant_c = '0;
    if (reset && enable) begin
      if (state == IDLE) grant_c = arb_grant;
      else if (elig[lock_idx]) grant_c[lock_idx] = 1'b1;
    end
  end

  // One-hot to index of the granted input.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NINPUTS; i++)
      if (grant_c[i]) gidx = PW'(i);
  end

  assign grant_any       = |grant_c;
  assign grant_tail      = bus.req_tail[gidx];
  assign next_ptr        = (gidx == PW'(NINPUTS - 1)) ? '0 : gidx + PW'(1);
  assign bus.grant       = grant_c;
  assign bus.grant_valid = grant_any;
  assign bus.grant_vc    = grant_any ? vcs[gidx] : '0;

  // Per-VC credit events; a grant and a return on the same VC cancel out.
  always_comb begin
    dec = '0;
    inc = '0;
    ovf = '0;
    for (int v = 0; v < NVCS; v++) begin
      dec[v] = grant_any && (bus.grant_vc == LW'(v));
      inc[v] = bus.credit_in_valid && (bus.credit_in_vc == LW'(v));
      ovf[v] = inc[v] && !dec[v] && (credit[v] == limit);
    end
  end

  // The locked input must keep targeting the VC its head flit claimed.
  assign vc_err    = (state == LOCKED) && bus.req[lock_idx] && (vcs[lock_idx] != lock_vc);
  assign cfg_limit = (config_in[CW-1:0] == '0) ? cnt_t'(CREDIT_MAX) : config_in[CW-1:0];
  assign is_quiescent = (state == IDLE) && !(|bus.req) && (credit == {NVCS{limit}});

  // Packet lock FSM and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      lock_vc  <= '0;
    end else begin
      if (grant_any) begin
        if (grant_tail) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state    <= LOCKED;
          lock_idx <= gidx;
          lock_vc  <= bus.grant_vc;
        end
      end
      if (config_in_valid) state <= IDLE;
    end
  end

  // Credit counters, limit register and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limit  <= cnt_t'(CREDIT_MAX);
      credit <= {NVCS{cnt_t'(CREDIT_MAX)}};
      error  <= 1'b0;
    end else begin
      if (config_in_valid) begin
        limit  <= cfg_limit;
        credit <= {NVCS{cfg_limit}};
      end else begin
        for (int v = 0; v < NVCS; v++) begin
          if (inc[v] && !dec[v]) begin
            if (credit[v] != limit) credit[v] <= credit[v] + cnt_t'(1);
          end else if (dec[v] && !inc[v]) begin
            credit[v] <= credit[v] - cnt_t'(1);
          end
        end
      end
      if ((|ovf) || vc_err) error <= 1'b1;
    end
  end

  // Config chain forwarding, one cycle of delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      config_out       <= '0;
      config_out_valid <= 1'b0;
    end else begin
      config_out       <= config_in;
      config_out_valid <= config_in_valid;
    end
  end

`ifdef SW_ALLOC_STATS_EN
  logic [STAT_W-1:0] stall_q;

  // Saturating count of cycles where someone wanted the port but got nothing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_q <= '0;
    else if (config_in_valid) stall_q <= '0;
    else if ((|bus.req) && enable && !grant_any && (stall_q != '1))
      stall_q <= stall_q + STAT_W'(1);
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
